// File: rtl/pop_rf_pkg.sv
// Shared types and width helpers for the double-buffered population register file.
package pop_rf_pkg;

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    FULL_WAIT = 1'b1
  } pop_state_e;

  localparam int GEN_CNT_W_DEF = 16;
  typedef logic [GEN_CNT_W_DEF-1:0] gen_cnt_t;

  // Pointer width: enough to index entries 0..n-1.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Read address width: one wider when n is a power of two so out-of-range requests are expressible.
  function automatic int addr_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pop_rf_bank.sv
// One population bank: single write port, NRP registered read ports with an out-of-range guard.
module pop_rf_bank
  import pop_rf_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int DW    = 8,
  parameter int NRP   = 2,
  parameter int WAW   = ptr_w(DEPTH),
  parameter int RAW   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [WAW-1:0]    i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [NRP-1:0]    i_rd_en,
  input  logic [NRP*RAW-1:0] i_raddr,
  input  logic              i_rd_zero,
  output logic [NRP*DW-1:0] o_rdata,
  output logic [NRP-1:0]    o_addr_err
);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [NRP*DW-1:0] r_rdata;
  logic [NRP-1:0]    r_addr_err;
  logic [NRP-1:0]    w_oor;

  always_comb begin
    w_oor = '0;
    for (int p = 0; p < NRP; p++) begin
      w_oor[p] = (i_raddr[p*RAW +: RAW] >= RAW'(DEPTH));
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data holds between requests; the error flag is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_addr_err <= '0;
    end else begin
      for (int p = 0; p < NRP; p++) begin
        r_addr_err[p] <= 1'b0;
        if (i_rd_en[p]) begin
          if (w_oor[p]) begin
            r_rdata[p*DW +: DW] <= '0;
            r_addr_err[p]       <= 1'b1;
          end else if (i_rd_zero) begin
            r_rdata[p*DW +: DW] <= '0;
          end else begin
            r_rdata[p*DW +: DW] <= r_mem[i_raddr[p*RAW +: WAW]];
          end
        end
      end
    end
  end

  assign o_rdata    = r_rdata;
  assign o_addr_err = r_addr_err;

endmodule

// File: rtl/pop_reg_file_mp.sv
// Double-buffered population register file: producer fills the back bank, evaluators read the front.
module pop_reg_file_mp
  import pop_rf_pkg::*;
#(
  parameter int POPSIZE      = 100,
  parameter int FRAME_SIZE   = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_RD_PORTS = 2,
  parameter int GEN_CNT_W    = 16,
  localparam int AW = addr_w(POPSIZE),
  localparam int PW = ptr_w(POPSIZE),
  localparam int FW = ptr_w(FRAME_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_rdy,
  output logic                               wr_ready,
  input  logic                               swap_hold,
  input  logic [NUM_RD_PORTS-1:0]            rd_rqst,
  input  logic [NUM_RD_PORTS*AW-1:0]         read_addr,
  output logic [NUM_RD_PORTS-1:0]            data_vld,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_RD_PORTS-1:0]            addr_err,
  output logic                               new_data,
  output logic                               gen_done,
  output logic [GEN_CNT_W-1:0]               gen_count,
  output logic                               front_valid,
  output logic [0:0]                         o_dbg_state
);

  localparam logic [0:0] ST_FILL      = FILL;
  localparam logic [0:0] ST_FULL_WAIT = FULL_WAIT;

  logic [0:0]              r_state;
  logic [PW-1:0]           r_wr_ptr;
  logic [FW-1:0]           r_frame_cnt;
  logic                    r_bank_sel;
  logic [GEN_CNT_W-1:0]    r_gen_count;
  logic                    r_front_valid;
  logic                    r_new_data;
  logic                    r_gen_done;
  logic [NUM_RD_PORTS-1:0] r_data_vld;
  logic [NUM_RD_PORTS-1:0] r_rd_bank;

  logic w_accept, w_last, w_frame_end, w_swap;
  logic [NUM_RD_PORTS-1:0] w_rd_en0, w_rd_en1, w_err0, w_err1;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] w_rdata0, w_rdata1;

  // Write handshake: a word transfers on a rising edge where data_rdy && wr_ready;
  // wr_ready is low only while a full back bank waits for swap_hold to clear.
  assign wr_ready    = (r_state == ST_FILL);
  assign w_accept    = data_rdy && wr_ready;
  assign w_last      = (r_wr_ptr == PW'(POPSIZE - 1));
  assign w_frame_end = (r_frame_cnt == FW'(FRAME_SIZE - 1));
  assign w_swap      = ((r_state == ST_FILL) && w_accept && w_last && !swap_hold) ||
                       ((r_state == ST_FULL_WAIT) && !swap_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_wr_ptr      <= '0;
      r_frame_cnt   <= '0;
      r_bank_sel    <= 1'b0;
      r_gen_count   <= '0;
      r_front_valid <= 1'b0;
      r_new_data    <= 1'b0;
      r_gen_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr    <= w_last ? '0 : r_wr_ptr + PW'(1);
        r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + FW'(1);
      end
      r_new_data <= w_accept && w_frame_end;
      r_gen_done <= w_swap;
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_gen_count   <= r_gen_count + GEN_CNT_W'(1);
        r_front_valid <= 1'b1;
      end
      case (r_state)
        ST_FILL:      if (w_accept && w_last && swap_hold) r_state <= ST_FULL_WAIT;
        ST_FULL_WAIT: if (!swap_hold) r_state <= ST_FILL;
        default:      r_state <= ST_FILL;
      endcase
    end
  end

  // Remember which bank served each port so data_out keeps its value across swaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_vld <= '0;
      r_rd_bank  <= '0;
    end else begin
      r_data_vld <= rd_rqst;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_rqst[p]) r_rd_bank[p] <= r_bank_sel;
      end
    end
  end

  assign w_rd_en0 = rd_rqst & {NUM_RD_PORTS{~r_bank_sel}};
  assign w_rd_en1 = rd_rqst & {NUM_RD_PORTS{r_bank_sel}};

  pop_rf_bank #(.DEPTH(POPSIZE), .DW(DATA_WIDTH), .NRP(NUM_RD_PORTS)) u_bank0 (
    .clk(clk), .rst(rst),
    .i_we(w_accept && r_bank_sel), .i_waddr(r_wr_ptr), .i_wdata(data_in),
    .i_rd_en(w_rd_en0), .i_raddr(read_addr), .i_rd_zero(!r_front_valid),
    .o_rdata(w_rdata0), .o_addr_err(w_err0)
  );

  pop_rf_bank #(.DEPTH(POPSIZE), .DW(DATA_WIDTH), .NRP(NUM_RD_PORTS)) u_bank1 (
    .clk(clk), .rst(rst),
    .i_we(w_accept && !r_bank_sel), .i_waddr(r_wr_ptr), .i_wdata(data_in),
    .i_rd_en(w_rd_en1), .i_raddr(read_addr), .i_rd_zero(!r_front_valid),
    .o_rdata(w_rdata1), .o_addr_err(w_err1)
  );

  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      data_out[p*DATA_WIDTH +: DATA_WIDTH] = r_rd_bank[p] ? w_rdata1[p*DATA_WIDTH +: DATA_WIDTH]
                                                          : w_rdata0[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign addr_err    = w_err0 | w_err1;
  assign data_vld    = r_data_vld;
  assign new_data    = r_new_data;
  assign gen_done    = r_gen_done;
  assign gen_count   = r_gen_count;
  assign front_valid = r_front_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pop_reg_file_mp.sv
// Directed scoreboard bench for pop_reg_file_mp at POPSIZE=8, FRAME_SIZE=4, two read ports.
module tb_pop_reg_file_mp;
  import pop_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        data_rdy = 1'b0;
  logic        wr_ready;
  logic        swap_hold = 1'b0;
  logic [1:0]  rd_rqst = '0;
  logic [7:0]  read_addr = '0;
  logic [1:0]  data_vld;
  logic [15:0] data_out;
  logic [1:0]  addr_err;
  logic        new_data;
  logic        gen_done;
  gen_cnt_t    gen_count;
  logic        front_valid;
  logic [0:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int n_new = 0;
  int n_gen = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  pop_reg_file_mp #(
    .POPSIZE(8), .FRAME_SIZE(4), .DATA_WIDTH(8), .NUM_RD_PORTS(2), .GEN_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_rdy(data_rdy), .wr_ready(wr_ready),
    .swap_hold(swap_hold), .rd_rqst(rd_rqst), .read_addr(read_addr), .data_vld(data_vld),
    .data_out(data_out), .addr_err(addr_err), .new_data(new_data), .gen_done(gen_done),
    .gen_count(gen_count), .front_valid(front_valid), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops one expected {addr_err, data} per data_vld pulse per port
  always @(negedge clk) begin
    if (!rst) begin
      if (new_data) n_new++;
      if (gen_done) n_gen++;
      if (data_vld[0]) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rd0_spurious: got %0h expected no response", {addr_err[0], data_out[7:0]});
        end else check("rd0", {addr_err[0], data_out[7:0]}, exp_q0.pop_front());
      end else if (addr_err[0]) check("err0_without_vld", addr_err[0], 1'b0);
      if (data_vld[1]) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL rd1_spurious: got %0h expected no response", {addr_err[1], data_out[15:8]});
        end else check("rd1", {addr_err[1], data_out[15:8]}, exp_q1.pop_front());
      end else if (addr_err[1]) check("err1_without_vld", addr_err[1], 1'b0);
    end
  end

  // driver: one clock of stimulus, inputs released 1 time unit after the edge
  task automatic step(input logic wr, input logic [7:0] d, input logic [1:0] rq,
                      input logic [3:0] a0, input logic [3:0] a1);
    data_rdy  = wr;
    data_in   = d;
    rd_rqst   = rq;
    read_addr = {a1, a0};
    @(posedge clk); #1;
    data_rdy = 1'b0;
    rd_rqst  = '0;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 2'b00, 4'd0, 4'd0);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 2'b00, 4'd0, 4'd0);
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic [8:0] e);
    if (p == 0) begin
      exp_q0.push_back(e);
      step(1'b0, 8'h00, 2'b01, a, 4'd0);
    end else begin
      exp_q1.push_back(e);
      step(1'b0, 8'h00, 2'b10, 4'd0, a);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_ready"}, wr_ready, 1'b1);
    check({tag, "_data_vld"}, data_vld, 2'b00);
    check({tag, "_addr_err"}, addr_err, 2'b00);
    check({tag, "_new_data"}, new_data, 1'b0);
    check({tag, "_gen_done"}, gen_done, 1'b0);
    check({tag, "_data_out"}, data_out, 16'h0000);
    check({tag, "_gen_count"}, gen_count, 16'd0);
    check({tag, "_front_valid"}, front_valid, 1'b0);
    check({tag, "_state"}, dbg_state, 1'b0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // read before any generation exists: zero data, no error
    rd(1, 4'd5, {1'b0, 8'h00});

    // first generation, swap unblocked
    for (int i = 0; i < 8; i++) begin
      wr(8'(8'h10 + i));
      check($sformatf("g1_new_data_w%0d", i + 1), new_data, (i == 3 || i == 7));
      check($sformatf("g1_gen_done_w%0d", i + 1), gen_done, (i == 7));
    end
    check("g1_gen_count", gen_count, 16'd1);
    check("g1_front_valid", front_valid, 1'b1);
    check("g1_wr_ready", wr_ready, 1'b1);
    rd(0, 4'd3, {1'b0, 8'h13});
    idle();
    check("hold_data_out", data_out[7:0], 8'h13);
    check("hold_data_vld", data_vld[0], 1'b0);

    // second generation with swap blocked
    swap_hold = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
    check("g2_wr_ready_low", wr_ready, 1'b0);
    check("g2_state_wait", dbg_state, 1'b1);
    check("g2_no_gen_done", gen_done, 1'b0);
    check("g2_gen_count_held", gen_count, 16'd1);
    wr(8'h99);
    check("g2_ignored_no_strobe", new_data, 1'b0);
    check("g2_still_blocked", wr_ready, 1'b0);
    rd(0, 4'd0, {1'b0, 8'h10});
    swap_hold = 1'b0;
    idle();
    check("g2_gen_done", gen_done, 1'b1);
    check("g2_gen_count", gen_count, 16'd2);
    check("g2_wr_ready_back", wr_ready, 1'b1);
    rd(0, 4'd0, {1'b0, 8'h20});

    // both ports in one cycle, one out of range
    exp_q0.push_back({1'b0, 8'h27});
    exp_q1.push_back({1'b1, 8'h00});
    step(1'b0, 8'h00, 2'b11, 4'd7, 4'd9);

    // read at the swap edge sees the old generation
    for (int i = 0; i < 7; i++) wr(8'(8'h30 + i));
    exp_q0.push_back({1'b0, 8'h22});
    step(1'b1, 8'h37, 2'b01, 4'd2, 4'd0);
    check("g3_gen_done", gen_done, 1'b1);
    check("g3_gen_count", gen_count, 16'd3);
    rd(0, 4'd2, {1'b0, 8'h32});
    rd(1, 4'd0, {1'b0, 8'h30});

    // reset mid-generation
    for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
    rst = 1'b1;
    idle();
    check_reset_values("midrst");
    rst = 1'b0;
    n_new = 0;
    n_gen = 0;
    for (int i = 0; i < 8; i++) begin
      wr(8'(8'h50 + i));
      check($sformatf("g4_new_data_w%0d", i + 1), new_data, (i == 3 || i == 7));
      check($sformatf("g4_gen_done_w%0d", i + 1), gen_done, (i == 7));
    end
    repeat (3) idle();
    check("g4_gen_done_count", n_gen, 1);
    check("g4_new_data_count", n_new, 2);
    check("g4_gen_count", gen_count, 16'd1);
    rd(1, 4'd4, {1'b0, 8'h54});

    repeat (3) idle();
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
